// File: rtl/search_coordinator.sv
// Iterative-deepening search coordinator: launches sequence_generator at lengths 1..limit
// and stops at the first length that produces a multiplier match. Optional watchdog: SEARCH_WDOG_EN.
module search_coordinator #(
   parameter int LEN_W       = 5,
   parameter int WDOG_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [LEN_W-1:0] len_limit,
   output logic             gen_start,
   output logic [LEN_W-1:0] gen_max_length,
   input  logic             gen_complete,
   input  logic             mul_match,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [LEN_W-1:0] found_length,
   output logic             timeout,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, RUN = 2'd2, FINISH = 2'd3} state_t;

   state_t           state;
   logic [LEN_W-1:0] limit;
   logic [LEN_W-1:0] cur_len;

   assign busy      = (state != IDLE);
   assign state_dbg = state;

`ifdef SEARCH_WDOG_EN
   localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
   logic [CNT_W-1:0] wdog_cnt;
   logic             timeout_q;
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   // gen_start and done are set on the transition into the state they belong to,
   // so both are clean registered single-cycle pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         limit          <= '0;
         cur_len        <= '0;
         gen_start      <= 1'b0;
         gen_max_length <= '0;
         done           <= 1'b0;
         found          <= 1'b0;
         found_length   <= '0;
`ifdef SEARCH_WDOG_EN
         wdog_cnt       <= '0;
         timeout_q      <= 1'b0;
`endif
      end else begin
         gen_start <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (go) begin
                  limit        <= len_limit;
                  found        <= 1'b0;
                  found_length <= '0;
                  cur_len      <= LEN_W'(1);
`ifdef SEARCH_WDOG_EN
                  timeout_q    <= 1'b0;
`endif
                  if (len_limit == '0) begin
                     state <= FINISH;
                  end else begin
                     state          <= LAUNCH;
                     gen_start      <= 1'b1;
                     gen_max_length <= LEN_W'(1);
                  end
               end
            end
            LAUNCH: begin
               state <= RUN;
`ifdef SEARCH_WDOG_EN
               wdog_cnt <= '0;
`endif
            end
            RUN: begin
               if (mul_match && !found) begin
                  found        <= 1'b1;
                  found_length <= cur_len;
               end
               // A match in the completing cycle still counts as found for this length.
               if (gen_complete) begin
                  if (found || mul_match || (cur_len == limit)) begin
                     state <= FINISH;
                  end else begin
                     cur_len        <= cur_len + LEN_W'(1);
                     gen_max_length <= cur_len + LEN_W'(1);
                     gen_start      <= 1'b1;
                     state          <= LAUNCH;
                  end
               end
`ifdef SEARCH_WDOG_EN
               else if (wdog_cnt == CNT_W'(WDOG_CYCLES - 1)) begin
                  timeout_q <= 1'b1;
                  state     <= FINISH;
               end else begin
                  wdog_cnt <= wdog_cnt + CNT_W'(1);
               end
`endif
            end
            FINISH: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_search_coordinator.sv
// Bench for search_coordinator: a behavioural generator/multiplier responder plus a
// reference model of which lengths must be launched and what the result must be.
module tb_search_coordinator;

   localparam int LEN_W = 5;
   localparam int WD    = 16;

   logic             clk = 1'b0;
   logic             reset, go, gen_complete, mul_match;
   logic [LEN_W-1:0] len_limit;
   logic             gen_start, busy, done, found, timeout;
   logic [LEN_W-1:0] gen_max_length, found_length;
   logic [1:0]       state_dbg;

   int checks   = 0;
   int failures = 0;
   logic [LEN_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   search_coordinator #(.LEN_W(LEN_W), .WDOG_CYCLES(WD)) dut (
      .clk(clk), .reset(reset), .go(go), .len_limit(len_limit),
      .gen_start(gen_start), .gen_max_length(gen_max_length),
      .gen_complete(gen_complete), .mul_match(mul_match),
      .busy(busy), .done(done), .found(found), .found_length(found_length),
      .timeout(timeout), .state_dbg(state_dbg)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One full search with a responder that completes each run after a random delay
   // and raises mul_match during the run of length mlen (0 = never matches).
   task automatic run_search(input int limit, input int mlen, input bit same,
                             input string tag, output int done_at);
      int   starts = 0, cnt = 0, d = 0, m = 0, last;
      bit   in_run = 0, fin = 0, hit;
      logic [LEN_W-1:0] cur = '0;
      hit  = (mlen >= 1) && (mlen <= limit);
      last = hit ? mlen : limit;
      exp_q.delete();
      for (int i = 1; i <= last; i++) exp_q.push_back(LEN_W'(i));
      done_at = -1;
      go = 1'b1; len_limit = LEN_W'(limit);
      step();
      go = 1'b0; len_limit = LEN_W'($urandom);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_found_clr"}, found, 0);
      for (int b = 0; b < 2000 && !fin; b++) begin
         gen_complete = 1'b0; mul_match = 1'b0;
         if (done) begin
            fin = 1; done_at = b;
         end else if (gen_start) begin
            starts++;
            cur = gen_max_length;
            if (exp_q.size() > 0) chk({tag, "_len"}, gen_max_length, exp_q.pop_front());
            in_run = 1; cnt = 0;
            d = $urandom_range(1, 4);
            m = same ? d : $urandom_range(1, d);
         end else if (in_run) begin
            cnt++;
            if (cnt == d) begin
               gen_complete = 1'b1; in_run = 0;
               chk({tag, "_stable"}, gen_max_length, cur);
            end
            if ((int'(cur) == mlen) && (cnt == m)) mul_match = 1'b1;
         end
         step();
      end
      gen_complete = 1'b0; mul_match = 1'b0;
      chk({tag, "_done_seen"}, fin, 1);
      chk({tag, "_starts"}, starts, last);
      chk({tag, "_found"}, found, hit);
      chk({tag, "_found_len"}, found_length, hit ? mlen : 0);
      chk({tag, "_timeout"}, timeout, 0);
      chk({tag, "_done_width"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int done_at, n_done, lim, ml;
      reset = 1'b1; go = 1'b0; gen_complete = 1'b0; mul_match = 1'b0; len_limit = '0;
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_start", gen_start, 0);
      chk("rst_len", gen_max_length, 0);
      chk("rst_found", found, 0);
      chk("rst_flen", found_length, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_state", state_dbg, 0);
      reset = 1'b0;
      step();

      // Generator handshakes while idle must not start anything or record a match.
      gen_complete = 1'b1; mul_match = 1'b1;
      step();
      gen_complete = 1'b0; mul_match = 1'b0;
      step();
      chk("idle_ign_busy", busy, 0);
      chk("idle_ign_start", gen_start, 0);
      chk("idle_ign_found", found, 0);

      run_search(3, 2, 0, "t1", done_at);
      run_search(3, 0, 0, "t2", done_at);
      run_search(0, 0, 0, "t3", done_at);
      chk("t3_done_latency", done_at, 1);
      run_search(4, 1, 1, "t4", done_at);
      run_search(31, 0, 0, "maxlim", done_at);
      run_search(31, 31, 1, "maxmatch", done_at);
      for (int r = 0; r < 10; r++) begin
         lim = $urandom_range(0, 8);
         ml  = $urandom_range(0, 10);
         run_search(lim, ml, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r), done_at);
      end

      // T5: go during RUN is ignored; reset mid-run clears everything without done.
      go = 1'b1; len_limit = LEN_W'(3);
      step();
      go = 1'b0;
      chk("t5_start1", gen_start, 1);
      step();
      go = 1'b1; len_limit = LEN_W'(1);
      step();
      go = 1'b0;
      gen_complete = 1'b1;
      step();
      gen_complete = 1'b0;
      chk("t5_start2", gen_start, 1);
      chk("t5_len2", gen_max_length, 2);
      step();
      reset = 1'b1;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_start", gen_start, 0);
      chk("t5_len", gen_max_length, 0);
      chk("t5_found", found, 0);
      chk("t5_flen", found_length, 0);
      chk("t5_done", done, 0);
      chk("t5_state", state_dbg, 0);
      step();
      reset = 1'b0;
      n_done = 0;
      for (int i = 0; i < 6; i++) begin
         if (done || busy) n_done++;
         step();
      end
      chk("t5_no_done", n_done, 0);

`ifdef SEARCH_WDOG_EN
      // T6: generator never completes; watchdog must end the search.
      go = 1'b1; len_limit = LEN_W'(2);
      step();
      go = 1'b0;
      chk("t6_start", gen_start, 1);
      done_at = -1;
      for (int i = 1; i < 40 && done_at < 0; i++) begin
         step();
         if (done) done_at = i;
      end
      chk("t6_latency_ok", (done_at >= 17) && (done_at <= 18), 1);
      chk("t6_timeout", timeout, 1);
      chk("t6_found", found, 0);
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
